// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
//
// Top-level controller for a "repeat the sequence" memory game. It builds a
// random digit sequence one nibble per cycle, asks the display block to play
// it back, enables the checker while the player answers, and keeps level,
// lives and score until the game is won or lost.
//
// Ports:
//   clk           - single clock, rising edge
//   rst           - synchronous active-high reset (highest priority)
//   start         - pulse: begin/restart a game (only honoured in IDLE/OVER/WIN)
//   rnd_in[3:0]   - random digit, sampled once per GEN cycle
//   display_done  - pulse from display block when playback has finished
//   correct       - pulse from checker: whole sequence entered correctly
//   incorrect     - pulse from checker: a wrong digit was entered
//   S_out[19:0]   - target sequence, digit i at S_out[19-4i -: 4]
//   LVL[2:0]      - current level (1..MAX_LVL) == sequence length
//   display_start - one-cycle playback request, high while in SHOW
//   check_en      - high while in PLAY
//   lives[1:0]    - remaining lives
//   score[7:0]    - accumulated score, saturating at 255
//   game_over     - high while in OVER
//   win           - high while in WIN
// -----------------------------------------------------------------------------
module game_sequencer #(
    parameter int          MAX_LVL     = 5,
    parameter int          START_LIVES = 3,
    parameter logic [15:0] TIMEOUT     = 16'd5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  rnd_in,
    input  logic        display_done,
    input  logic        correct,
    input  logic        incorrect,
    output logic [19:0] S_out,
    output logic [2:0]  LVL,
    output logic        display_start,
    output logic        check_en,
    output logic [1:0]  lives,
    output logic [7:0]  score,
    output logic        game_over,
    output logic        win
);

    localparam logic [2:0] MAX_LVL_L     = 3'(MAX_LVL);
    localparam logic [1:0] START_LIVES_L = 2'(START_LIVES);

    typedef enum logic [3:0] {
        IDLE,
        GEN,
        SHOW,
        WAIT_DISP,
        PLAY,
        PASS,
        FAIL,
        OVER,
        WIN
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  gen_cnt;   // digits generated so far at this level
    logic [15:0] tcnt;      // cycles spent in PLAY

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [2:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {6'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE, OVER, WIN: begin
                if (start)
                    state_next = GEN;
            end
            GEN: begin
                if (gen_cnt + 3'd1 == LVL)
                    state_next = SHOW;
            end
            SHOW: state_next = WAIT_DISP;
            WAIT_DISP: begin
                if (display_done)
                    state_next = PLAY;
            end
            PLAY: begin
                // A wrong digit or an expired timer beats a simultaneous correct.
                if (incorrect || (tcnt == TIMEOUT - 16'd1))
                    state_next = FAIL;
                else if (correct)
                    state_next = PASS;
            end
            PASS: state_next = (LVL == MAX_LVL_L) ? WIN : GEN;
            FAIL: state_next = (lives <= 2'd1) ? OVER : SHOW;
            default: state_next = IDLE;
        endcase
    end

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            S_out         <= 20'd0;
            LVL           <= 3'd1;
            lives         <= START_LIVES_L;
            score         <= 8'd0;
            display_start <= 1'b0;
            check_en      <= 1'b0;
            game_over     <= 1'b0;
            win           <= 1'b0;
            tcnt          <= 16'd0;
            gen_cnt       <= 3'd0;
        end else begin
            state <= state_next;

            // Status outputs are decoded from the next state so that they are
            // registered yet line up exactly with the state they describe.
            display_start <= (state_next == SHOW);
            check_en      <= (state_next == PLAY);
            game_over     <= (state_next == OVER);
            win           <= (state_next == WIN);

            case (state)
                IDLE, OVER, WIN: begin
                    if (start) begin
                        LVL     <= 3'd1;
                        lives   <= START_LIVES_L;
                        score   <= 8'd0;
                        S_out   <= 20'd0;
                        gen_cnt <= 3'd0;
                        tcnt    <= 16'd0;
                    end
                end
                GEN: begin
                    // First generated digit lands in the most significant nibble.
                    for (int i = 0; i < 5; i++) begin
                        if (gen_cnt == 3'(i))
                            S_out[19-4*i -: 4] <= rnd_in;
                    end
                    gen_cnt <= gen_cnt + 3'd1;
                end
                WAIT_DISP: begin
                    if (display_done)
                        tcnt <= 16'd0;
                end
                PLAY: begin
                    tcnt <= tcnt + 16'd1;
                end
                PASS: begin
                    score <= sat_add(score, LVL);
                    if (LVL != MAX_LVL_L) begin
                        LVL     <= LVL + 3'd1;
                        S_out   <= 20'd0;
                        gen_cnt <= 3'd0;
                    end
                end
                FAIL: begin
                    if (lives != 2'd0)
                        lives <= lives - 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_sequencer
//
// Directed bench for game_sequencer. Inputs change 1 ns after a rising edge
// and outputs are observed 1 ns after the following edge. A short TIMEOUT is
// used so the timeout path is reached quickly.
// -----------------------------------------------------------------------------
module tb_game_sequencer;

    localparam logic [15:0] TB_TIMEOUT = 16'd20;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  rnd_in;
    logic        display_done;
    logic        correct;
    logic        incorrect;
    logic [19:0] S_out;
    logic [2:0]  LVL;
    logic        display_start;
    logic        check_en;
    logic [1:0]  lives;
    logic [7:0]  score;
    logic        game_over;
    logic        win;

    int n_cmp;
    int n_bad;

    game_sequencer #(
        .MAX_LVL     (5),
        .START_LIVES (3),
        .TIMEOUT     (TB_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .rnd_in        (rnd_in),
        .display_done  (display_done),
        .correct       (correct),
        .incorrect     (incorrect),
        .S_out         (S_out),
        .LVL           (LVL),
        .display_start (display_start),
        .check_en      (check_en),
        .lives         (lives),
        .score         (score),
        .game_over     (game_over),
        .win           (win)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no_finish, need finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, need 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive n digits (taken MSB-first from digs) on successive GEN cycles.
    task automatic gen_seq(input int n, input logic [19:0] digs);
        for (int i = 0; i < n; i++) begin
            rnd_in = digs[19-4*i -: 4];
            tick();
        end
        rnd_in = 4'd0;
    endtask

    // From SHOW: go through WAIT_DISP into PLAY.
    task automatic to_play();
        tick();                 // SHOW -> WAIT_DISP
        display_done = 1'b1;
        tick();                 // WAIT_DISP -> PLAY
        display_done = 1'b0;
    endtask

    task automatic pulse_correct();
        correct = 1'b1;
        tick();                 // PLAY -> PASS
        correct = 1'b0;
        tick();                 // PASS -> GEN / WIN
    endtask

    task automatic pulse_incorrect();
        incorrect = 1'b1;
        tick();                 // PLAY -> FAIL
        incorrect = 1'b0;
        tick();                 // FAIL -> SHOW / OVER
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        rst          = 1'b1;
        start        = 1'b0;
        rnd_in       = 4'd0;
        display_done = 1'b0;
        correct      = 1'b0;
        incorrect    = 1'b0;
        @(posedge clk);
        #1;
        tick();
        rst = 1'b0;

        // Reset state
        check_eq("rst_S_out", 32'(S_out), 32'h0);
        check_eq("rst_LVL", 32'(LVL), 32'd1);
        check_eq("rst_lives", 32'(lives), 32'd3);
        check_eq("rst_score", 32'(score), 32'd0);
        check_eq("rst_flags", 32'({display_start, check_en, game_over, win}), 32'h0);

        // Game 1, level 1: single digit 7
        start = 1'b1;
        tick();
        start = 1'b0;
        gen_seq(1, 20'h70000);
        check_eq("l1_S_out", 32'(S_out), 32'h70000);
        check_eq("l1_disp_start", 32'(display_start), 32'd1);
        tick();                 // WAIT_DISP
        check_eq("l1_disp_start_one", 32'(display_start), 32'd0);

        // Checker pulses while waiting for display are ignored
        incorrect = 1'b1;
        tick();
        incorrect = 1'b0;
        correct = 1'b1;
        tick();
        correct = 1'b0;
        check_eq("wait_ignore_lives", 32'(lives), 32'd3);
        check_eq("wait_ignore_chk", 32'(check_en), 32'd0);
        display_done = 1'b1;
        tick();
        display_done = 1'b0;
        check_eq("l1_check_en", 32'(check_en), 32'd1);
        pulse_correct();
        check_eq("l1_pass_score", 32'(score), 32'd1);
        check_eq("l1_pass_LVL", 32'(LVL), 32'd2);

        // Level 2: digits 5,9, then advance to level 3
        gen_seq(2, 20'h59000);
        check_eq("l2_S_out", 32'(S_out), 32'h59000);
        to_play();
        pulse_correct();
        check_eq("l2_pass_score", 32'(score), 32'd3);
        check_eq("l2_pass_LVL", 32'(LVL), 32'd3);
        check_eq("l2_pass_clear", 32'(S_out), 32'h0);

        // Level 3: three GEN cycles, display_start only after the third
        gen_seq(2, 20'hAB000);
        check_eq("l3_gen_no_ds", 32'(display_start), 32'd0);
        rnd_in = 4'hC;
        tick();
        rnd_in = 4'd0;
        check_eq("l3_gen_ds", 32'(display_start), 32'd1);
        check_eq("l3_S_out", 32'(S_out), 32'hABC00);

        // Timeout: PLAY lasts exactly TB_TIMEOUT cycles with no response
        to_play();
        for (int i = 0; i < int'(TB_TIMEOUT) - 1; i++) tick();
        check_eq("to_still_play", 32'(check_en), 32'd1);
        tick();
        check_eq("to_fail", 32'(check_en), 32'd0);
        tick();
        check_eq("to_lives", 32'(lives), 32'd2);
        check_eq("to_replay_ds", 32'(display_start), 32'd1);
        check_eq("to_replay_S", 32'(S_out), 32'hABC00);
        check_eq("to_replay_LVL", 32'(LVL), 32'd3);

        // Tie: correct and incorrect together takes the fail path
        to_play();
        correct = 1'b1;
        pulse_incorrect();
        correct = 1'b0;
        check_eq("tie_lives", 32'(lives), 32'd1);
        check_eq("tie_score", 32'(score), 32'd3);
        check_eq("tie_ds", 32'(display_start), 32'd1);

        // Reset during PLAY at level 3, with start in the same cycle
        to_play();
        check_eq("pre_rst_chk", 32'(check_en), 32'd1);
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check_eq("mid_rst_S", 32'(S_out), 32'h0);
        check_eq("mid_rst_LVL", 32'(LVL), 32'd1);
        check_eq("mid_rst_lives", 32'(lives), 32'd3);
        check_eq("mid_rst_score", 32'(score), 32'd0);
        check_eq("mid_rst_flags", 32'({display_start, check_en, game_over, win}), 32'h0);
        tick();
        tick();
        check_eq("rst_stay_idle", 32'({display_start, check_en}), 32'h0);

        // Game 2: lose all lives at level 1
        start = 1'b1;
        tick();
        start = 1'b0;
        gen_seq(1, 20'h40000);
        to_play();
        pulse_incorrect();
        check_eq("g2_lives2", 32'(lives), 32'd2);
        check_eq("g2_S2", 32'(S_out), 32'h40000);
        to_play();
        pulse_incorrect();
        check_eq("g2_lives1", 32'(lives), 32'd1);
        check_eq("g2_S1", 32'(S_out), 32'h40000);
        to_play();
        pulse_incorrect();
        check_eq("g2_lives0", 32'(lives), 32'd0);
        check_eq("g2_over", 32'(game_over), 32'd1);
        check_eq("g2_S0", 32'(S_out), 32'h40000);
        tick();
        check_eq("g2_hold", 32'({game_over, lives}), 32'h4);

        // Game 3: restart from OVER and win through all five levels
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("g3_restart_go", 32'(game_over), 32'd0);
        check_eq("g3_restart_lives", 32'(lives), 32'd3);
        gen_seq(1, 20'h10000);
        to_play();
        pulse_correct();
        gen_seq(2, 20'h21000);
        to_play();
        pulse_correct();
        gen_seq(3, 20'h32100);
        to_play();
        // start in PLAY is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("play_start_ign", 32'({check_en, LVL}), 32'hB);
        pulse_correct();
        gen_seq(4, 20'h43210);
        to_play();
        pulse_correct();
        gen_seq(5, 20'h123AC);
        check_eq("l5_S_out", 32'(S_out), 32'h123AC);
        to_play();
        pulse_correct();
        check_eq("win_flag", 32'(win), 32'd1);
        check_eq("win_score", 32'(score), 32'd15);
        check_eq("win_LVL", 32'(LVL), 32'd5);
        check_eq("win_S_hold", 32'(S_out), 32'h123AC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter MAX_LVL, default 5, meaning the highest level; the sequence length at level L is L digits.
REQ-002 SHALL have parameter START_LIVES, default 3, meaning the lives granted at game start (range 1..3).
REQ-003 SHALL have parameter TIMEOUT, default 16'd5000, meaning the clk cycles allowed in PLAY before a forced failure.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge triggered.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: single-cycle pulse that begins or restarts a game.
REQ-007 SHALL have port rnd_in, input, 4 bits: random digit source, sampled during GEN.
REQ-008 SHALL have port display_done, input, 1 bit: pulse from the display block when playback ends.
REQ-009 SHALL have port correct, input, 1 bit: pulse from the sequence checker on a full correct entry.
REQ-010 SHALL have port incorrect, input, 1 bit: pulse from the sequence checker on a wrong digit.
REQ-011 SHALL have port S_out, output, 20 bits: target sequence for the checker and display.
REQ-012 SHALL have port LVL, output, 3 bits: current level, 1..MAX_LVL.
REQ-013 SHALL have port display_start, output, 1 bit: single-cycle pulse that requests playback.
REQ-014 SHALL have port check_en, output, 1 bit: high only in PLAY.
REQ-015 SHALL have port lives, output, 2 bits: remaining lives.
REQ-016 SHALL have port score, output, 8 bits: accumulated score.
REQ-017 SHALL have ports game_over and win, output, 1 bit each: terminal status flags.

Function
REQ-018 SHALL implement the states IDLE, GEN, SHOW, WAIT_DISP, PLAY, PASS, FAIL, OVER and WIN.
REQ-019 IDLE: on start, SHALL load LVL=1, lives=START_LIVES, score=0 and S_out=0, then go to GEN.
REQ-020 GEN: SHALL take exactly LVL cycles, each cycle shifting in rnd_in as the next digit. Digit i (entry order, 0-based) SHALL be at S_out[19-4i:16-4i]. Unused low nibbles SHALL be 0. Next state is SHOW.
REQ-021 SHOW: SHALL assert display_start for exactly one cycle, then go to WAIT_DISP.
REQ-022 WAIT_DISP: SHALL hold until display_done=1, then go to PLAY and clear the timeout counter.
REQ-023 PLAY: check_en=1 and the counter increments each cycle. On incorrect, or when the counter reaches TIMEOUT-1, SHALL go to FAIL. Otherwise on correct, SHALL go to PASS.
REQ-024 If correct and incorrect assert in the same cycle, incorrect SHALL win.
REQ-025 correct, incorrect and display_done SHALL be ignored outside PLAY and WAIT_DISP respectively.
REQ-026 PASS (one cycle): score SHALL increase by LVL, saturating at 255. If LVL==MAX_LVL, SHALL go to WIN. Otherwise SHALL set LVL=LVL+1, clear S_out and go to GEN.
REQ-027 FAIL (one cycle): if lives==1, SHALL set lives=0 and go to OVER. Otherwise SHALL decrement lives and go to SHOW, replaying the unchanged S_out at the same LVL.
REQ-028 OVER: game_over=1. WIN: win=1. In both, S_out, LVL and score SHALL be held.
REQ-029 In OVER or WIN, start SHALL behave as in IDLE (REQ-019). start SHALL be ignored in all other states.
REQ-030 Outputs SHALL be registered; display_start asserts in the cycle after entry to SHOW.
REQ-031 LVL SHALL never exceed MAX_LVL. lives SHALL never underflow.

Reset
REQ-032 When rst=1 at a rising edge, SHALL enter IDLE in any state, including mid-GEN and mid-PLAY.
REQ-033 Reset values SHALL be: S_out=0, LVL=1, lives=START_LIVES, score=0, display_start=0, check_en=0, game_over=0, win=0, timeout counter=0.
REQ-034 rst SHALL take priority over start and all other inputs in the same cycle.

Verification
REQ-035 Sequence build: start, then rnd_in=1,2,3,A,C on successive GEN cycles at LVL 5 -> S_out=20'h123AC. At LVL 1 with rnd_in=7 -> S_out=20'h70000.
REQ-036 Level advance: at LVL=2, display_done then correct -> score +2, LVL=3, three GEN cycles follow, then a one-cycle display_start.
REQ-037 Lives: three incorrect pulses in PLAY -> lives goes 3, 2, 1, 0, game_over=1, S_out unchanged on each replay.
REQ-038 Win and tie: correct at LVL 1..5 -> win=1, score=15. correct and incorrect together -> FAIL path taken.
REQ-039 Timeout: no response for TIMEOUT cycles in PLAY -> FAIL with lives decremented. An incorrect pulse during WAIT_DISP -> no effect.
REQ-040 Reset: rst=1 during PLAY at LVL 3 -> next cycle IDLE with all outputs at their reset values. start in the same cycle as rst -> stays in IDLE.
